// File: rtl/logic_unit_pkg.sv
// Shared types for the bitwise logic unit: op encoding and its width.
package logic_unit_pkg;

    localparam int LU_OP_W = 3;

    typedef enum logic [LU_OP_W-1:0] {
        LU_AND, LU_ORR, LU_EOR, LU_BIC, LU_ORN, LU_EON, LU_MOV, LU_MVN
    } lu_op_t;

endpackage

// File: rtl/logic_unit_core.sv
// Combinational ARM logical-op core built from per-bit gate primitives.
// Shared by the pipelined unit and the single-cycle datapath.
module logic_unit_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  lu_op_t             op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   r
);

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            wire nb, t_and, t_orr, t_eor, t_bic, t_orn, t_eon;

            not u_nb  (nb,    b[i]);
            and u_and (t_and, a[i], b[i]);
            or  u_orr (t_orr, a[i], b[i]);
            xor u_eor (t_eor, a[i], b[i]);
            and u_bic (t_bic, a[i], nb);
            or  u_orn (t_orn, a[i], nb);
            xor u_eon (t_eon, a[i], nb);

            // Candidate order follows the op encoding so the op selects directly.
            wire [7:0] cand = {nb, a[i], t_eon, t_orn, t_bic, t_eor, t_orr, t_and};
            assign r[i] = cand[op];
        end
    endgenerate

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined logic unit with valid/ready on both sides.
// S1 holds operands, S2 holds result, flags and tag.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int TAG_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LU_OP_W-1:0] in_op,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_result,
    output logic               out_n,
    output logic               out_z,
    output logic [TAG_W-1:0]   out_tag
);

    logic             s1_valid;
    lu_op_t           s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [TAG_W-1:0] s1_tag;
    logic             s2_valid;
    logic [WIDTH-1:0] r;
    logic             s1_adv;
    logic             s2_adv;

    // in_ready sees out_ready combinationally so a full pipe can still stream.
    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    logic_unit_core #(.WIDTH(WIDTH)) u_core (
        .op (s1_op),
        .a  (s1_a),
        .b  (s1_b),
        .r  (r)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_op    <= LU_AND;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_tag   <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op  <= lu_op_t'(in_op);
                s1_a   <= in_a;
                s1_b   <= in_b;
                s1_tag <= in_tag;
            end
        end
    end

    // Flags are registered with the result so they always match out_result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_valid   <= 1'b0;
            out_result <= '0;
            out_n      <= 1'b0;
            out_z      <= 1'b0;
            out_tag    <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_result <= r;
                out_n      <= r[WIDTH-1];
                out_z      <= ~|r;
                out_tag    <= s1_tag;
            end
        end
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe at WIDTH 64, 32 and 1.
module tb_logic_unit_pipe;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, out_valid, out_ready, out_n, out_z;
    logic [2:0]  in_op;
    logic [63:0] in_a, in_b, out_result;
    logic [4:0]  in_tag, out_tag;

    logic        v1_in, v1_rdy, v1_ov, v1_a, v1_b, v1_tag, v1_res, v1_n, v1_z, v1_otag;
    logic        v32_in, v32_rdy, v32_ov, v32_n, v32_z;
    logic [31:0] v32_a, v32_b, v32_res;
    logic [4:0]  v32_tag, v32_otag;

    int n_chk  = 0;
    int n_fail = 0;

    logic_unit_pipe #(.WIDTH(64), .TAG_W(5)) u64 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_n(out_n), .out_z(out_z), .out_tag(out_tag)
    );

    logic_unit_pipe #(.WIDTH(1), .TAG_W(1)) u1 (
        .clk(clk), .reset(reset), .in_valid(v1_in), .in_ready(v1_rdy),
        .in_op(in_op), .in_a(v1_a), .in_b(v1_b), .in_tag(v1_tag),
        .out_valid(v1_ov), .out_ready(1'b1), .out_result(v1_res),
        .out_n(v1_n), .out_z(v1_z), .out_tag(v1_otag)
    );

    logic_unit_pipe #(.WIDTH(32), .TAG_W(5)) u32 (
        .clk(clk), .reset(reset), .in_valid(v32_in), .in_ready(v32_rdy),
        .in_op(in_op), .in_a(v32_a), .in_b(v32_b), .in_tag(v32_tag),
        .out_valid(v32_ov), .out_ready(1'b1), .out_result(v32_res),
        .out_n(v32_n), .out_z(v32_z), .out_tag(v32_otag)
    );

    function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [63:0] a,
                                           input logic [63:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return a & ~b;
            3'd4:    return a | ~b;
            3'd5:    return a ^ ~b;
            3'd6:    return a;
            default: return ~b;
        endcase
    endfunction

    task automatic chk(input string tg, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tg, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [63:0] A = 64'hF0F0_F0F0_0000_FFFF;
    localparam logic [63:0] B = 64'hFF00_FF00_FFFF_0000;

    logic [63:0] exp_r [8] = '{
        64'hF000_F000_0000_0000, 64'hFFF0_FFF0_FFFF_FFFF,
        64'h0FF0_0FF0_FFFF_FFFF, 64'h00F0_00F0_0000_FFFF,
        64'hF0FF_F0FF_0000_FFFF, 64'hF00F_F00F_0000_0000,
        64'hF0F0_F0F0_0000_FFFF, 64'h00FF_00FF_0000_FFFF
    };
    logic exp_n [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    logic [63:0] q_r [$];
    logic [4:0]  q_t [$];

    initial begin
        logic [63:0] m, er;
        logic [4:0]  et;
        int acc, cyc;

        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_op = '0;
        in_a = '0; in_b = '0; in_tag = '0;
        v1_in = 1'b0; v1_a = 1'b0; v1_b = 1'b0; v1_tag = 1'b0;
        v32_in = 1'b0; v32_a = '0; v32_b = '0; v32_tag = '0;

        #3;
        chk("rst_valid",  128'(out_valid),  128'(0));
        chk("rst_result", 128'(out_result), 128'(0));
        chk("rst_flags",  128'({out_n, out_z}), 128'(0));
        chk("rst_tag",    128'(out_tag),    128'(0));
        chk("rst_sweep_valid", 128'({v1_ov, v32_ov}), 128'(0));

        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rel_in_ready", 128'(in_ready), 128'(1));

        // Op table: all 8 ops streamed back to back on all three widths.
        for (int k = 0; k < 10; k++) begin
            in_valid = (k < 8); in_op = 3'(k); in_a = A; in_b = B; in_tag = 5'(k + 10);
            v1_in = (k < 8); v1_a = A[0]; v1_b = B[0]; v1_tag = 1'(k);
            v32_in = (k < 8); v32_a = A[31:0]; v32_b = B[31:0]; v32_tag = 5'(k);
            tick();
            if (k == 0) chk("lat_not_early", 128'(out_valid), 128'(0));
            if (k >= 1 && k <= 8) begin
                chk("op_valid",  128'(out_valid),  128'(1));
                chk("op_result", 128'(out_result), 128'(exp_r[k-1]));
                chk("op_n",      128'(out_n),      128'(exp_n[k-1]));
                chk("op_z",      128'(out_z),      128'(0));
                chk("op_tag",    128'(out_tag),    128'(k + 9));
                m = ref_op(3'(k - 1), A, B);
                chk("w1_result", 128'({v1_ov, v1_res, v1_n, v1_z, v1_otag}),
                    128'({1'b1, m[0], m[0], ~m[0], 1'(k - 1)}));
                chk("w32_result", 128'({v32_ov, v32_res, v32_n, v32_z, v32_otag}),
                    128'({1'b1, m[31:0], m[31], (m[31:0] == 32'd0), 5'(k - 1)}));
                chk("sweep_ready", 128'({v1_rdy, v32_rdy}), 128'(2'b11));
            end
            if (k == 9) chk("op_drained", 128'(out_valid), 128'(0));
        end
        v1_in = 1'b0; v32_in = 1'b0;

        // Flag corners.
        in_valid = 1'b1; in_op = 3'd0; in_a = {32{2'b01}}; in_b = {32{2'b10}}; in_tag = 5'd1;
        tick();
        in_op = 3'd7; in_a = 64'h1234; in_b = '0; in_tag = 5'd2;
        tick();
        in_valid = 1'b0;
        chk("flag_and", 128'({out_result, out_n, out_z}), 128'({64'd0, 1'b0, 1'b1}));
        tick();
        chk("flag_mvn", 128'({out_result, out_n, out_z}), 128'({{64{1'b1}}, 1'b1, 1'b0}));
        tick();

        // Backpressure: two ops fill the pipe, the third is held off.
        out_ready = 1'b0; in_valid = 1'b1; in_op = 3'd6; in_b = '0;
        in_a = 64'd1; in_tag = 5'd1;
        tick();
        in_a = 64'd2; in_tag = 5'd2;
        tick();
        in_a = 64'd3; in_tag = 5'd3;
        #1;
        chk("bp_full_ready", 128'(in_ready), 128'(0));
        for (int s = 0; s < 5; s++) begin
            tick();
            chk("bp_stall", 128'({out_valid, out_tag, out_result, in_ready}),
                128'({1'b1, 5'd1, 64'd1, 1'b0}));
        end
        out_ready = 1'b1;
        #1;
        chk("bp_ready_comb", 128'(in_ready), 128'(1));
        tick();
        in_valid = 1'b0;
        chk("bp_tag2", 128'({out_valid, out_tag}), 128'({1'b1, 5'd2}));
        tick();
        chk("bp_tag3", 128'({out_valid, out_tag}), 128'({1'b1, 5'd3}));
        tick();
        chk("bp_empty", 128'(out_valid), 128'(0));

        // Random ops with random backpressure against an in-order scoreboard.
        acc = 0; cyc = 0;
        while (acc < 1000 && cyc < 5000) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_op = 3'($urandom); in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
            in_tag = 5'($urandom); out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                if (q_r.size() == 0) chk("rand_extra", 128'(out_valid), 128'(0));
                else begin
                    er = q_r.pop_front(); et = q_t.pop_front();
                    chk("rand_res", 128'({out_result, out_tag}), 128'({er, et}));
                    chk("rand_flags", 128'({out_n, out_z}), 128'({er[63], er == 64'd0}));
                end
            end
            if (in_valid && in_ready) begin
                q_r.push_back(ref_op(in_op, in_a, in_b)); q_t.push_back(in_tag); acc++;
            end
            tick();
            cyc++;
        end
        chk("rand_accepts", 128'(acc), 128'(1000));
        in_valid = 1'b0; out_ready = 1'b1;
        for (int d = 0; d < 10; d++) begin
            if (out_valid) begin
                if (q_r.size() == 0) chk("drain_extra", 128'(out_valid), 128'(0));
                else begin
                    er = q_r.pop_front(); et = q_t.pop_front();
                    chk("drain_res", 128'({out_result, out_tag}), 128'({er, et}));
                end
            end
            tick();
        end
        chk("rand_lost", 128'(q_r.size()), 128'(0));

        // Reset with two ops in flight.
        out_ready = 1'b0; in_valid = 1'b1; in_op = 3'd6; in_b = '0;
        in_a = 64'd4; in_tag = 5'd4;
        tick();
        in_a = 64'd5; in_tag = 5'd5;
        tick();
        in_valid = 1'b0;
        chk("pre_rst_full", 128'({out_valid, out_tag}), 128'({1'b1, 5'd4}));
        #1 reset = 1'b0;
        #1;
        chk("async_rst", 128'({out_valid, out_result, out_n, out_z, out_tag}), 128'(0));
        #1 reset = 1'b1;
        in_valid = 1'b1; in_a = 64'd7; in_tag = 5'd7; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("post_rst_no_stale", 128'(out_valid), 128'(0));
        tick();
        chk("post_rst_op", 128'({out_valid, out_tag, out_result}), 128'({1'b1, 5'd7, 64'd7}));
        tick();
        chk("post_rst_empty", 128'(out_valid), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, pipelined bitwise logic unit for the EX stage.
- Performs the ARM logical ops: AND, ORR, EOR, BIC, ORN, EON, MOV and MVN.
- Two register stages, with valid/ready handshakes on the input and output sides.
- Produces a result, N/Z flags and a pass-through tag so the issue logic can match results back to instructions.

Parameters:
- WIDTH, 64: operand and result width in bits; legal range 1..128.
- TAG_W, 5: width of the sideband tag (destination register index).

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-low reset; assertion clears all state.
- in_valid, input, 1: an operation is offered.
- in_ready, output, 1: the unit accepts the operation this cycle.
- in_op, input, 3: op code; encoding below.
- in_a, input, WIDTH: operand A.
- in_b, input, WIDTH: operand B.
- in_tag, input, TAG_W: sideband tag, carried unchanged.
- out_valid, output, 1: result is presented.
- out_ready, input, 1: consumer takes the result this cycle.
- out_result, output, WIDTH: result.
- out_n, output, 1: result[WIDTH-1].
- out_z, output, 1: result == 0.
- out_tag, output, TAG_W: tag of the presented result.

Behaviour:
- Op encoding (3 bits), result R:
  - 000 AND: R = A&B
  - 001 ORR: R = A|B
  - 010 EOR: R = A^B
  - 011 BIC: R = A&~B
  - 100 ORN: R = A|~B
  - 101 EON: R = A^~B
  - 110 MOV: R = A
  - 111 MVN: R = ~B
- All ops are purely bitwise at width WIDTH; no carry or overflow.
- Stage 1 (S1): registers op, A, B and tag on an input handshake (in_valid && in_ready); s1_valid is set.
- Stage 2 (S2): computes R from the S1 registers and registers R, N, Z and tag; s2_valid drives out_valid.
- Advance rules:
  - s2_adv = !s2_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv; this combinational path from out_ready is allowed.
- S2 update on s2_adv: s2_valid <= s1_valid; payload loads only when s1_valid.
- S1 update on s1_adv: s1_valid <= in_valid; payload loads only when in_valid.
- Latency: accept in cycle t gives out_valid at t+2 with no stall.
- Throughput: 1 op/cycle while out_ready is held high.
- Stall (out_valid && !out_ready):
  - out_result, out_n, out_z and out_tag hold stable.
  - in_ready is 0 when S1 is also full.
  - A full pipe holds exactly 2 ops; nothing is dropped or duplicated.
- Simultaneous accept and emit in one cycle with the pipe full: S2 takes S1's op and S1 takes the new op; order is preserved.
- in_valid low: S1 empties if it advances; payload registers need not change.
- Reset assertion:
  - Asynchronously clears s1_valid and s2_valid.
  - out_valid=0, out_result=0, out_n=0, out_z=0, out_tag=0; S1 payload registers clear to 0.
  - In-flight ops are discarded with no recovery.
  - in_ready reads 1 while reset is deasserted and the pipe is empty.
- Reset deassertion: first accept is possible on the first clk edge after release.
- out_z and out_n always correspond to out_result, including while stalled.
- WIDTH=1: out_n equals out_result[0] and out_z equals !out_result[0].
- Undefined ops: none; every 3-bit code is defined.

Decomposition:
- Package logic_unit_pkg holds:
  - typedef enum logic [2:0] lu_op_t {LU_AND, LU_ORR, LU_EOR, LU_BIC, LU_ORN, LU_EON, LU_MOV, LU_MVN}
  - localparam LU_OP_W = 3
- One combinational sub-module, logic_unit_core (op, a, b -> r), parametrised by WIDTH.
  - Built from per-bit generate loops of gate primitives, matching the existing 64-bit gate-level blocks.
  - Also reused by the single-cycle datapath.
- logic_unit_pipe holds only the two register stages, the handshake and the flag generation.

Test Plan:
- Basic ops at WIDTH=64, out_ready=1. Stream all 8 ops with A=0xF0F0_F0F0_0000_FFFF, B=0xFF00_FF00_FFFF_0000. Results in order, each 2 cycles after accept:
  - AND = 0xF000_F000_0000_0000
  - ORR = 0xFFF0_FFF0_FFFF_FFFF
  - EOR = 0x0FF0_0FF0_FFFF_FFFF
  - BIC = 0x00F0_00F0_0000_FFFF
  - MVN = 0x00FF_00FF_0000_FFFF
  - Z and N checked per result.
- Flags: AND with A=0x5555..., B=0xAAAA... gives R=0, Z=1, N=0. MVN with B=0 gives R=all-ones, Z=0, N=1.
- Backpressure: send tags 1,2,3 back-to-back with out_ready=0.
  - After 2 accepts in_ready=0; tag 3 is held off.
  - out_tag=1 stays stable across 5 stall cycles.
  - Raising out_ready yields tags 1,2,3 in consecutive cycles.
- Full throughput with random out_ready: 1000 random ops. The scoreboard matches every result/tag in order, with no loss or duplication.
- Reset mid-operation: reset low with 2 ops in flight.
  - Outputs go to 0 and out_valid=0 immediately, without waiting for clk.
  - After release, the next op (tag 7) emerges at accept+2, with no stale results.
- Parameter sweep: WIDTH=1, TAG_W=1 and WIDTH=32 pass the op-table scenario above against a reference model.
